// File: rtl/diamond_pkg.sv
// rtl/diamond_pkg.sv - shared constants and types for the diamond tracker
// Contents: default coordinate width and diamond size, slot limit,
// coordinate type and per-slot state encoding.
package diamond_pkg;

  localparam int COORD_W      = 10;
  localparam int DIAM_SIZE    = 20;
  localparam int MAX_DIAMONDS = 15;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    AVAIL = 1'b0,
    EATEN = 1'b1
  } slot_state_e;

endpackage

// File: rtl/diamond_hit.sv
// rtl/diamond_hit.sv - combinational player-box / diamond overlap check for one slot
// Ports:
//   valid                     slot present in the current level
//   left, right, top, bottom  player box edges, inclusive, COORD_W+1 bits
//   dx, dy                    diamond top-left corner
//   hit                       box overlaps [dx, dx+DIAM_SIZE) x [dy, dy+DIAM_SIZE)
module diamond_hit #(
  parameter int COORD_W   = diamond_pkg::COORD_W,
  parameter int DIAM_SIZE = diamond_pkg::DIAM_SIZE
) (
  input  logic               valid,
  input  logic [COORD_W:0]   left,
  input  logic [COORD_W:0]   right,
  input  logic [COORD_W:0]   top,
  input  logic [COORD_W:0]   bottom,
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  output logic               hit
);

  import diamond_pkg::*;

  logic [COORD_W:0] dx_ext;
  logic [COORD_W:0] dy_ext;
  logic [COORD_W:0] dx_end;
  logic [COORD_W:0] dy_end;

  // The extra bit keeps dx+DIAM_SIZE from wrapping near the screen edge.
  assign dx_ext = {1'b0, dx};
  assign dy_ext = {1'b0, dy};
  assign dx_end = dx_ext + (COORD_W+1)'(DIAM_SIZE);
  assign dy_end = dy_ext + (COORD_W+1)'(DIAM_SIZE);

  assign hit = valid
             & (left < dx_end) & (right >= dx_ext)
             & (top  < dy_end) & (bottom >= dy_ext);

endmodule

// File: rtl/diamond_tracker.sv
// rtl/diamond_tracker.sv - per-player diamond collection tracker
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   frame_tick                 collisions sampled only on this strobe
//   level_load                 clears all eaten state (wins over frame_tick)
//   x, y, width, height        player centre and box size
//   diam_x, diam_y, diam_valid packed per-slot diamond corners and presence
//   eaten, num_eaten           sticky per-slot flags and their popcount
//   collect_pulse/collect_mask one-cycle event with the newly eaten slots
//   all_eaten                  every valid slot eaten, at least one valid
module diamond_tracker #(
  parameter int NUM_DIAMONDS = 3,
  parameter int DIAM_SIZE    = diamond_pkg::DIAM_SIZE,
  parameter int COORD_W      = diamond_pkg::COORD_W,
  parameter int CNT_W        = 4
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              frame_tick,
  input  logic                              level_load,
  input  logic [COORD_W-1:0]                x,
  input  logic [COORD_W-1:0]                y,
  input  logic [6:0]                        width,
  input  logic [6:0]                        height,
  input  logic [NUM_DIAMONDS*COORD_W-1:0]   diam_x,
  input  logic [NUM_DIAMONDS*COORD_W-1:0]   diam_y,
  input  logic [NUM_DIAMONDS-1:0]           diam_valid,
  output logic [NUM_DIAMONDS-1:0]           eaten,
  output logic [CNT_W-1:0]                  num_eaten,
  output logic                              collect_pulse,
  output logic [NUM_DIAMONDS-1:0]           collect_mask,
  output logic                              all_eaten
);

  import diamond_pkg::*;

  localparam int BW = COORD_W + 1;

  logic [BW-1:0] x_ext, y_ext, half_w, half_h;
  logic [BW-1:0] box_left, box_right, box_top, box_bottom;

  logic [NUM_DIAMONDS-1:0] hit;
  logic [NUM_DIAMONDS-1:0] new_eaten;
  logic [NUM_DIAMONDS-1:0] eaten_d;
  logic [CNT_W-1:0]        cnt_d;

  slot_state_e state_q [NUM_DIAMONDS];
  slot_state_e state_d [NUM_DIAMONDS];

  // Player box, computed once and shared by every slot comparator.
  assign x_ext  = {1'b0, x};
  assign y_ext  = {1'b0, y};
  assign half_w = BW'(width >> 1);
  assign half_h = BW'(height >> 1);

  // Clamp at the screen edge instead of letting the subtraction wrap.
  assign box_left   = (x_ext < half_w) ? '0 : x_ext - half_w;
  assign box_top    = (y_ext < half_h) ? '0 : y_ext - half_h;
  assign box_right  = x_ext + half_w;
  assign box_bottom = y_ext + half_h;

  for (genvar i = 0; i < NUM_DIAMONDS; i++) begin : g_hit
    diamond_hit #(
      .COORD_W   (COORD_W),
      .DIAM_SIZE (DIAM_SIZE)
    ) u_hit (
      .valid  (diam_valid[i]),
      .left   (box_left),
      .right  (box_right),
      .top    (box_top),
      .bottom (box_bottom),
      .dx     (diam_x[i*COORD_W +: COORD_W]),
      .dy     (diam_y[i*COORD_W +: COORD_W]),
      .hit    (hit[i])
    );
  end

  // Per-slot next state; level_load overrides any hit on the same tick.
  always_comb begin
    new_eaten = '0;
    eaten_d   = '0;
    for (int i = 0; i < NUM_DIAMONDS; i++) begin
      state_d[i] = state_q[i];
      if (level_load) begin
        state_d[i] = AVAIL;
      end else if (frame_tick && hit[i]) begin
        state_d[i] = EATEN;
        new_eaten[i] = (state_q[i] == AVAIL);
      end
      eaten_d[i] = (state_d[i] == EATEN);
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_DIAMONDS; i++) begin
      cnt_d = cnt_d + CNT_W'(eaten_d[i]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_DIAMONDS; i++) begin
        state_q[i] <= AVAIL;
      end
      num_eaten     <= '0;
      collect_pulse <= 1'b0;
      collect_mask  <= '0;
      all_eaten     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIAMONDS; i++) begin
        state_q[i] <= state_d[i];
      end
      // Count and completion follow the next-state vector so they never
      // lag eaten by a cycle.
      num_eaten     <= cnt_d;
      collect_pulse <= |new_eaten;
      collect_mask  <= new_eaten;
      // Slots dropped from the level keep their flag but stop counting here.
      all_eaten     <= (&(eaten_d | ~diam_valid)) & (|diam_valid);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIAMONDS; i++) begin
      eaten[i] = (state_q[i] == EATEN);
    end
  end

endmodule
